// File: rtl/tri_scan_drv_if.sv
//==============================================================================
// Module      : tri_scan_drv_if
// Description : Host-side request/response bundle for the scan ring driver.
//               The master modport belongs to the requester and the slave
//               modport to tri_scan_drv.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface tri_scan_drv_if #(
  parameter int RING_LEN = 32
);
  logic                start;
  logic                op_wr;
  logic [0:RING_LEN-1] wr_data;
  logic                abort;
  logic                busy;
  logic                done;
  logic [0:RING_LEN-1] rd_data;

  modport master (
    output start, op_wr, wr_data, abort,
    input  busy, done, rd_data
  );

  modport slave (
    input  start, op_wr, wr_data, abort,
    output busy, done, rd_data
  );
endinterface

`default_nettype wire

// File: rtl/tri_scan_drv.sv
//==============================================================================
// Module      : tri_scan_drv
// Description : Drives one serial scan ring. An accepted request freezes the
//               functional clocks, shifts RING_LEN bits through the ring
//               (either a new load image or the ring's own output for a
//               non-destructive rotate), captures the bits coming back out
//               and presents them on rd_data with a one-cycle done pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef NCLK_WIDTH
`define NCLK_WIDTH 4
`endif

module tri_scan_drv #(
  parameter int RING_LEN  = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic [0:`NCLK_WIDTH-1] nclk,
  input  logic                   rst_b,
  inout  wire                    vd,
  inout  wire                    gd,
  tri_scan_drv_if.slave          host,
  output logic                   scan_dout,
  input  logic                   scan_din,
  output logic                   scan_thold_b,
  output logic                   func_thold_b
);

  // Index width needed to address one ring bit; the counter may be wider.
  localparam int                   c_idx_w    = $clog2(RING_LEN);
  localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(RING_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DISARM = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  logic                 w_clk;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [c_idx_w-1:0]   w_idx;
  logic [0:RING_LEN-1]  r_shadow;
  logic                 r_op_wr;
  logic [0:RING_LEN-1]  r_capture;
  logic [0:RING_LEN-1]  r_rd_data;
  logic                 w_accept;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_scan_dout;
  logic                 w_scan_thold_b;
  logic                 w_func_thold_b;
  logic                 w_unused;

  // Only bit 0 of the clock bundle is a real clock.
  assign w_clk = nclk[0];

  // Sink for the unused clock bits and the supply pins; nothing consumes it.
  assign w_unused = ^{nclk, vd, gd};

  assign w_idx    = r_cnt[c_idx_w-1:0];
  assign w_accept = (r_state == ST_IDLE) && host.start && !host.abort;

  // State register.
  always_ff @(posedge w_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode; abort overrides every non-idle transition.
  always_comb begin
    w_state_nxt    = r_state;
    w_busy         = 1'b1;
    w_done         = 1'b0;
    w_scan_thold_b = 1'b0;
    w_func_thold_b = 1'b0;
    w_scan_dout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy         = 1'b0;
        w_func_thold_b = 1'b1;
        if (host.start && !host.abort) begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_scan_thold_b = 1'b1;
        // Load drives the shadow image bit 0 first; rotate feeds the ring
        // its own output so the contents come back unchanged.
        w_scan_dout    = r_op_wr ? r_shadow[w_idx] : scan_din;
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = ST_DISARM;
        end
      end
      ST_DISARM: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_func_thold_b = 1'b1;
        w_done         = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if ((r_state != ST_IDLE) && host.abort) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Request capture, shift counting (saturating at the last bit) and unload.
  always_ff @(posedge w_clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_op_wr   <= 1'b0;
      r_capture <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_shadow <= host.wr_data;
        r_op_wr  <= host.op_wr;
      end else if ((r_state == ST_SHIFT) && (r_cnt != c_cnt_last)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (r_state == ST_SHIFT) begin
        r_capture[w_idx] <= scan_din;
      end
      // Publish the unloaded image only when the operation really completes.
      if ((r_state == ST_DISARM) && !host.abort) begin
        r_rd_data <= r_capture;
      end
    end
  end

  assign host.busy    = w_busy;
  assign host.done    = w_done;
  assign host.rd_data = r_rd_data;
  assign scan_dout    = w_scan_dout;
  assign scan_thold_b = w_scan_thold_b;
  assign func_thold_b = w_func_thold_b;

endmodule

`default_nettype wire

// File: tb/tb_tri_scan_drv.sv
//==============================================================================
// Module      : tb_tri_scan_drv
// Description : Self-checking bench for tri_scan_drv with an 8-latch ring.
//               The ring image is modelled as a FIFO of bits in exit order.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef NCLK_WIDTH
`define NCLK_WIDTH 4
`endif

module tb_tri_scan_drv;

  localparam int L  = 8;
  localparam int CW = 3;
  localparam int NW = `NCLK_WIDTH;

  logic          clk = 1'b0;
  logic [0:NW-1] nclk;
  logic          rst_b;
  wire           vd;
  wire           gd;
  logic          scan_dout;
  logic          scan_din;
  logic          scan_thold_b;
  logic          func_thold_b;

  int checks = 0;
  int errors = 0;

  // Reference: ring image, element 0 is the next bit to leave the ring.
  logic          img[$];
  logic [0:L-1]  model_rd = '0;

  // Physical ring of latches driven by the DUT; index L-1 feeds scan_din.
  logic [0:L-1]  ring = '0;

  tri_scan_drv_if #(.RING_LEN(L)) host_if ();

  assign vd = 1'b1;
  assign gd = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    nclk    = '0;
    nclk[0] = clk;
  end

  assign scan_din = ring[L-1];

  always @(posedge clk) begin
    if (scan_thold_b) ring <= {scan_dout, ring[0:L-2]};
  end

  tri_scan_drv #(.RING_LEN(L), .CNT_WIDTH(CW)) dut (
    .nclk         (nclk),
    .rst_b        (rst_b),
    .vd           (vd),
    .gd           (gd),
    .host         (host_if),
    .scan_dout    (scan_dout),
    .scan_din     (scan_din),
    .scan_thold_b (scan_thold_b),
    .func_thold_b (func_thold_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:L-1] img_vec();
    logic [0:L-1] v;
    for (int i = 0; i < L; i++) v[i] = img[i];
    return v;
  endfunction

  // n shifts: each pops the exit bit and pushes either the load bit or the
  // popped bit itself (rotate). Returns the bits that left, in order.
  function automatic logic [0:L-1] model_shift(int n, logic op, logic [0:L-1] wr);
    logic [0:L-1] out = '0;
    logic b;
    for (int i = 0; i < n; i++) begin
      b = img.pop_front();
      out[i] = b;
      img.push_back(op ? wr[i] : b);
    end
    return out;
  endfunction

  // One operation from IDLE. abort_t in 1..L+2 aborts in that cycle, 0 = none.
  // Cycle t after acceptance: 1 ARM, 2..L+1 SHIFT, L+2 DISARM, L+3 DONE.
  task automatic run_op(input logic op, input logic [0:L-1] wr, input int abort_t, input string tag);
    logic [0:L-1] cur;
    int           nthold;
    int           n;
    cur = img_vec();
    nthold = 0;
    host_if.start   = 1'b1;
    host_if.op_wr   = op;
    host_if.wr_data = wr;
    host_if.abort   = 1'b0;
    cyc();
    host_if.start   = 1'b0;
    host_if.wr_data = L'($urandom);
    for (int t = 1; t <= L + 4; t++) begin
      chk($sformatf("%s busy t=%0d", tag, t), host_if.busy, (t <= L + 3));
      chk($sformatf("%s done t=%0d", tag, t), host_if.done, (t == L + 3));
      chk($sformatf("%s scan_thold_b t=%0d", tag, t), scan_thold_b, (t >= 2 && t <= L + 1));
      chk($sformatf("%s func_thold_b t=%0d", tag, t), func_thold_b, (t >= L + 3));
      if (t >= 2 && t <= L + 1)
        chk($sformatf("%s scan_dout t=%0d", tag, t), scan_dout, op ? wr[t-2] : cur[t-2]);
      else
        chk($sformatf("%s scan_dout t=%0d", tag, t), scan_dout, 1'b0);
      if (scan_thold_b) nthold++;
      if (t == L + 3) model_rd = model_shift(L, op, wr);
      chk($sformatf("%s rd_data t=%0d", tag, t), host_if.rd_data, model_rd);
      if (t == abort_t) begin
        host_if.abort = 1'b1;
        host_if.start = 1'b0;
        cyc();
        host_if.abort = 1'b0;
        n = ((t < L + 1) ? t : L + 1) - 1;
        void'(model_shift(n, op, wr));
        chk({tag, " abort busy"}, host_if.busy, 1'b0);
        chk({tag, " abort done"}, host_if.done, 1'b0);
        chk({tag, " abort scan_thold_b"}, scan_thold_b, 1'b0);
        chk({tag, " abort func_thold_b"}, func_thold_b, 1'b1);
        chk({tag, " abort rd_data"}, host_if.rd_data, model_rd);
        return;
      end
      // Requests while busy must be dropped, not queued.
      host_if.start   = (t <= L + 3) ? 1'($urandom) : 1'b0;
      host_if.op_wr   = 1'($urandom);
      host_if.wr_data = L'($urandom);
      if (t < L + 4) cyc();
    end
    chk({tag, " thold cycles"}, nthold, L);
  endtask

  initial begin
    logic [0:L-1] w;
    int           abt;
    for (int i = 0; i < L; i++) img.push_back(1'b0);
    rst_b           = 1'b0;
    host_if.start   = 1'b0;
    host_if.op_wr   = 1'b0;
    host_if.wr_data = '0;
    host_if.abort   = 1'b0;
    #12;
    chk("reset busy", host_if.busy, 1'b0);
    chk("reset done", host_if.done, 1'b0);
    chk("reset rd_data", host_if.rd_data, 8'h00);
    chk("reset scan_dout", scan_dout, 1'b0);
    chk("reset scan_thold_b", scan_thold_b, 1'b0);
    chk("reset func_thold_b", func_thold_b, 1'b1);
    rst_b = 1'b1;

    // Load into an all-zero ring, then rotate it back out.
    run_op(1'b1, 8'b1011_0001, 0, "load1");
    chk("load1 rd const", host_if.rd_data, 8'h00);
    run_op(1'b0, 8'h00, 0, "rot1");
    chk("rot1 rd const", host_if.rd_data, 8'b1011_0001);
    run_op(1'b1, 8'hA5, 0, "loadA5");
    chk("loadA5 rd const", host_if.rd_data, 8'b1011_0001);
    run_op(1'b0, 8'h00, 0, "rotA5a");
    chk("rotA5a rd const", host_if.rd_data, 8'hA5);
    run_op(1'b0, 8'hFF, 0, "rotA5b");
    chk("rotA5b rd const", host_if.rd_data, 8'hA5);

    // Abort in SHIFT cycle 3: four shifts happened, ring rotated by four.
    run_op(1'b0, 8'h00, 5, "abort_shift3");
    chk("abort_shift3 rd const", host_if.rd_data, 8'hA5);
    cyc();
    chk("abort_shift3 func later", func_thold_b, 1'b1);
    run_op(1'b0, 8'h00, 0, "rot_after_abort");
    chk("rot_after_abort rd const", host_if.rd_data, 8'h5A);

    // Abort in ARM (no shift) and in DISARM (full load already shifted).
    run_op(1'b1, 8'hFF, 1, "abort_arm");
    run_op(1'b1, 8'h3C, L + 2, "abort_disarm");
    chk("abort_disarm rd const", host_if.rd_data, 8'h5A);
    run_op(1'b0, 8'h00, 0, "rot_after_disarm");
    chk("rot_after_disarm rd const", host_if.rd_data, 8'h3C);

    // start and abort together in IDLE: nothing starts.
    host_if.start = 1'b1;
    host_if.abort = 1'b1;
    cyc();
    chk("start_abort busy", host_if.busy, 1'b0);
    chk("start_abort func_thold_b", func_thold_b, 1'b1);
    host_if.start = 1'b0;
    host_if.abort = 1'b0;
    cyc();
    chk("start_abort not queued", host_if.busy, 1'b0);

    // start held high: one rotate accepted every L+4 cycles.
    host_if.start = 1'b1;
    host_if.op_wr = 1'b0;
    cyc();
    for (int t = 1; t <= 3 * (L + 4); t++) begin
      chk($sformatf("held busy t=%0d", t), host_if.busy, ((t % (L + 4)) != 0));
      chk($sformatf("held done t=%0d", t), host_if.done, ((t % (L + 4)) == L + 3));
      if (t < 3 * (L + 4)) cyc();
    end
    host_if.start = 1'b0;
    model_rd = img_vec();
    chk("held rd_data", host_if.rd_data, model_rd);

    // Reset between edges in SHIFT cycle 2 (two shifts already done).
    host_if.start = 1'b1;
    host_if.op_wr = 1'b0;
    cyc();
    host_if.start = 1'b0;
    cyc();
    cyc();
    cyc();
    #3;
    rst_b = 1'b0;
    #1;
    chk("midreset busy", host_if.busy, 1'b0);
    chk("midreset done", host_if.done, 1'b0);
    chk("midreset rd_data", host_if.rd_data, 8'h00);
    chk("midreset scan_dout", scan_dout, 1'b0);
    chk("midreset scan_thold_b", scan_thold_b, 1'b0);
    chk("midreset func_thold_b", func_thold_b, 1'b1);
    void'(model_shift(2, 1'b0, 8'h00));
    model_rd = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("midreset held busy", host_if.busy, 1'b0);
    chk("midreset held scan_thold_b", scan_thold_b, 1'b0);
    rst_b = 1'b1;
    run_op(1'b0, 8'h00, 0, "post_reset");

    // Randomized operations with occasional aborts.
    for (int k = 0; k < 20; k++) begin
      w   = L'($urandom);
      abt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, L + 2)) : 0;
      run_op(1'($urandom), w, abt, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/tri_scan_drv.md
TRI_SCAN_DRV -- requirements
Module: tri_scan_drv

Interface
REQ-001 Parameter RING_LEN, default 32: number of scan latches in the driven ring; legal range 2..64.
REQ-002 Parameter CNT_WIDTH, default 6: shift counter width; SHALL satisfy 2**CNT_WIDTH >= RING_LEN.
REQ-003 Port nclk, input, [0:`NCLK_WIDTH-1]: nclk[0] is the single clock, rising edge; all other bits are unused.
REQ-004 Port rst_b, input, 1: reset, asynchronous, active-low.
REQ-005 Ports vd and gd, inout, 1 each: power and ground; SHALL NOT be referenced functionally.
REQ-006 Port start, input, 1: operation request; sampled only in IDLE.
REQ-007 Port op_wr, input, 1: sampled with start; 1 = load ring from wr_data, 0 = rotate (ring contents preserved).
REQ-008 Port wr_data, input, [0:RING_LEN-1]: load image; captured when start is accepted.
REQ-009 Port abort, input, 1: terminate the current operation.
REQ-010 Port busy, output, 1: operation in progress.
REQ-011 Port done, output, 1: one-cycle completion pulse.
REQ-012 Port rd_data, output, [0:RING_LEN-1]: prior ring image unloaded by the last completed operation.
REQ-013 Port scan_dout, output, 1: serial data to the ring's first scin.
REQ-014 Port scan_din, input, 1: serial data from the ring's last scout.
REQ-015 Port scan_thold_b, output, 1: 1 = ring shift clock enabled.
REQ-016 Port func_thold_b, output, 1: 0 = functional clocks of the ring domain frozen.

Function
REQ-017 FSM states SHALL be IDLE, ARM, SHIFT, DISARM and DONE.
REQ-018 FSM transitions SHALL be:
- IDLE->ARM on start=1 with abort=0.
- ARM->SHIFT unconditionally.
- SHIFT->DISARM after exactly RING_LEN SHIFT cycles.
- DISARM->DONE unconditionally.
- DONE->IDLE unconditionally.
REQ-019 On start acceptance, the block SHALL capture wr_data and op_wr into shadow registers and clear the shift counter to 0.
REQ-020 busy SHALL be 1 in ARM, SHIFT, DISARM and DONE, and 0 in IDLE.
REQ-021 func_thold_b SHALL be 0 in ARM, SHIFT and DISARM, and 1 otherwise.
REQ-022 scan_thold_b SHALL be 1 only in SHIFT.
REQ-023 scan_dout in SHIFT SHALL be selected as follows:
- Load mode: shadow bit [cnt], cnt = 0..RING_LEN-1, so bit 0 is sent first.
- Rotate mode: scan_din, combinational pass-through.
REQ-024 scan_dout SHALL be 0 outside SHIFT.
REQ-025 In SHIFT cycle cnt, scan_din SHALL be sampled into capture bit [cnt].
REQ-026 rd_data SHALL be updated from the capture register on entry to DONE, so it is valid in the DONE cycle and held until the next DONE.
REQ-027 done SHALL be 1 only in DONE.
REQ-028 Latency: with start accepted at edge 0, done SHALL be high in cycle RING_LEN+3 and the block SHALL re-accept start from cycle RING_LEN+4.
REQ-029 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-030 Abort behaviour:
- abort=1 in any state other than IDLE SHALL force IDLE at the next edge with no done pulse.
- rd_data SHALL be unchanged by an aborted operation.
- scan_thold_b and func_thold_b SHALL be at their IDLE values in the cycle after abort.
REQ-031 start=1 and abort=1 together in IDLE: abort SHALL win and no operation starts.
REQ-032 wr_data changes after acceptance SHALL NOT affect the operation in progress.
REQ-033 The counter SHALL NOT wrap: it stops at RING_LEN-1 and is cleared on the next acceptance.

Reset
REQ-034 rst_b=0 SHALL asynchronously force the following values, held while rst_b=0:
- State IDLE, shift counter 0, shadow and capture registers 0.
- busy=0, done=0, rd_data=0, scan_dout=0, scan_thold_b=0, func_thold_b=1.
REQ-035 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-036 The first start SHALL be accepted on the first rising edge after rst_b deasserts.

Verification
REQ-037 Loading a model ring of 8 latches initialised to 0 (RING_LEN=8) SHALL give the following:
- Stimulus: start=1, op_wr=1, wr_data=8'b1011_0001.
- done pulses in cycle 11 with rd_data=0.
- A second rotate then returns rd_data=8'b1011_0001 and leaves the ring unchanged.
REQ-038 Rotate twice on a ring holding 8'hA5 -> both operations SHALL return rd_data=8'hA5, and scan_thold_b SHALL be high for exactly 8 cycles per operation.
REQ-039 abort in SHIFT cycle 3 -> IDLE next cycle, no done, rd_data keeps its previous value, func_thold_b=1 one cycle later.
REQ-040 start held high continuously -> operations accepted only every RING_LEN+4 cycles, and done never overlaps ARM.
REQ-041 rst_b low during SHIFT, between clock edges -> all outputs take their reset values immediately, and start is accepted at the first edge after release.
REQ-042 start and abort together in IDLE -> busy stays 0 and func_thold_b stays 1.
